// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port owner: serialises ICache fetches and LSB loads/stores into byte beats.
// Loads win over fetches; IO stores stall per beat on io_buffer_full; flush drops reads only.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic        ls_enable,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  len_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        if_valid_q;
  logic        ls_valid_q;
  logic [31:0] if_inst_q;
  logic [31:0] ls_rdata_q;

  logic [2:0]  ls_len;
  logic [31:0] beat_addr;
  logic [1:0]  cap_idx;
  logic [31:0] data_d;
  logic        io_stall;

  assign ls_len    = (ls_size == 2'd2) ? 3'd4 : {1'b0, ls_size} + 3'd1;
  assign beat_addr = addr_q + {29'd0, cnt_q};
  assign io_stall  = io_buffer_full && (beat_addr >= IO_BASE);

  // At edge with cnt_q = j (j >= 2) the byte driven two cycles earlier, index j-2, is on mem_din.
  assign cap_idx = cnt_q[1:0] - 2'd2;

  always_comb begin
    data_d = data_q;
    if (cnt_q >= 3'd2) begin
      data_d[{cap_idx, 3'b000} +: 8] = mem_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      if_inst_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if_valid_q <= 1'b0;
          ls_valid_q <= 1'b0;
          mem_a_q    <= 32'd0;
          mem_wr_q   <= 1'b0;
          data_q     <= 32'd0;
          if (!flush && ls_enable) begin
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            len_q   <= ls_len;
            mem_a_q <= ls_addr;
            if (ls_wr) begin
              state_q <= STORE;
              if (io_buffer_full && (ls_addr >= IO_BASE)) begin
                cnt_q <= 3'd0;
              end else begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= ls_wdata[7:0];
                cnt_q      <= 3'd1;
              end
            end else begin
              state_q <= LOAD;
              cnt_q   <= 3'd1;
            end
          end else if (!flush && if_enable) begin
            addr_q  <= if_addr;
            len_q   <= 3'd4;
            mem_a_q <= if_addr;
            state_q <= IFETCH;
            cnt_q   <= 3'd1;
          end
        end
        IFETCH, LOAD: begin
          if (flush) begin
            state_q <= IDLE;
            mem_a_q <= 32'd0;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            data_q  <= data_d;
            mem_a_q <= (cnt_q < len_q) ? beat_addr : 32'd0;
            if (cnt_q == len_q + 3'd1) begin
              state_q <= IDLE;
              if (state_q == IFETCH) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= data_d;
              end else begin
                ls_valid_q <= 1'b1;
                ls_rdata_q <= data_d;
              end
            end
          end
        end
        STORE: begin
          if (cnt_q == len_q) begin
            state_q    <= IDLE;
            ls_valid_q <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_a_q    <= 32'd0;
          end else begin
            mem_a_q <= beat_addr;
            if (io_stall) begin
              mem_wr_q <= 1'b0;
            end else begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
              cnt_q      <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign ls_valid = ls_valid_q;
  assign ls_rdata = ls_rdata_q;

endmodule
